// File: rtl/montgomery_cios_serial.sv
// Word-serial CIOS Montgomery multiplier: result = a * b * 2^(-DATA_LENGTH) mod m.
// One BLOCK_LENGTH x BLOCK_LENGTH multiply per cycle, shared by the MUL, QCALC and RED phases.
// Optional build macro MONTGOMERY_FINAL_SUB_EN adds a limb-serial final subtraction (SUB) so result < m.
module montgomery_cios_serial #(
    parameter int DATA_LENGTH  = 64,
    parameter int BLOCK_LENGTH = 16
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    start_i,
    input  logic [DATA_LENGTH-1:0]  a_i,
    input  logic [DATA_LENGTH-1:0]  b_i,
    input  logic [DATA_LENGTH-1:0]  m_i,
    input  logic [BLOCK_LENGTH-1:0] m_prime_i,
    output logic                    busy_o,
    output logic                    done_o,
    output logic                    error_o,
    output logic [DATA_LENGTH-1:0]  result_o,
    output logic [2:0]              dbg_state
);
    localparam int NUM_BLOCKS = DATA_LENGTH / BLOCK_LENGTH;
    localparam int TW         = DATA_LENGTH + 2 * BLOCK_LENGTH;
    localparam int CW         = $clog2(NUM_BLOCKS);
    localparam int BL         = BLOCK_LENGTH;

    generate
        if ((DATA_LENGTH % BLOCK_LENGTH) != 0 || NUM_BLOCKS < 2) begin : g_bad_cfg
            $error("DATA_LENGTH must be a multiple of BLOCK_LENGTH with at least two blocks");
        end
    endgenerate

    typedef enum logic [2:0] {IDLE, MUL, QCALC, RED, SUB, FINISH} state_t;

`ifdef MONTGOMERY_FINAL_SUB_EN
    localparam state_t AFTER_RED = SUB;
`else
    localparam state_t AFTER_RED = FINISH;
`endif

    // Handshake: a request is taken when start_i is high while busy_o is low (IDLE) and m_i is odd;
    // an even modulus is refused with a one-cycle error_o pulse; done_o marks result_o valid for one cycle.
    state_t              state, state_next;
    logic [DATA_LENGTH-1:0] a_r, b_r, m_r, result;
    logic [BL-1:0]       mp_r, q, carry, carry_next, mul_x, mul_y;
    logic [2*BL-1:0]     prod, acc;
    logic [BL:0]         top;
    logic [TW-1:0]       t, t_next;
    logic [CW-1:0]       i_cnt, j_cnt;
    logic                error_r, accept, j_last, i_last;
    int                  jb, ib;

    assign accept = (state == IDLE) && start_i && m_i[0];
    assign j_last = (j_cnt == CW'(NUM_BLOCKS - 1));
    assign i_last = (i_cnt == CW'(NUM_BLOCKS - 1));
    assign jb     = int'(j_cnt) * BL;
    assign ib     = int'(i_cnt) * BL;

    assign busy_o    = (state != IDLE);
    assign done_o    = (state == FINISH);
    assign error_o   = error_r;
    assign result_o  = result;
    assign dbg_state = state;

    // Operand select for the single shared limb multiplier
    always_comb begin
        mul_x = a_r[jb +: BL];
        mul_y = b_r[ib +: BL];
        if (state == QCALC) begin
            mul_x = t[BL-1:0];
            mul_y = mp_r;
        end else if (state == RED) begin
            mul_x = m_r[jb +: BL];
            mul_y = q;
        end
    end

    assign prod = {{BL{1'b0}}, mul_x} * {{BL{1'b0}}, mul_y};

    // Accumulator update: multiply-accumulate in MUL, reduce-and-shift in RED
    always_comb begin
        t_next     = t;
        carry_next = carry;
        acc        = '0;
        top        = '0;
        case (state)
            IDLE: begin
                t_next     = '0;
                carry_next = '0;
            end
            MUL: begin
                acc = {{BL{1'b0}}, t[jb +: BL]} + prod + {{BL{1'b0}}, carry};
                t_next[jb +: BL] = acc[BL-1:0];
                carry_next = acc[2*BL-1:BL];
                if (j_last) begin
                    top = {1'b0, t[NUM_BLOCKS*BL +: BL]} + {1'b0, carry_next};
                    t_next[NUM_BLOCKS*BL +: BL]     = top[BL-1:0];
                    t_next[(NUM_BLOCKS+1)*BL +: BL] = {{(BL-1){1'b0}}, top[BL]};
                    carry_next = '0;
                end
            end
            RED: begin
                // Limb j is written one position down, which folds the shift into the write
                acc = {{BL{1'b0}}, t[jb +: BL]} + prod + {{BL{1'b0}}, carry};
                if (j_cnt != '0) t_next[jb - BL +: BL] = acc[BL-1:0];
                carry_next = acc[2*BL-1:BL];
                if (j_last) begin
                    top = {1'b0, t[NUM_BLOCKS*BL +: BL]} + {1'b0, carry_next};
                    t_next[(NUM_BLOCKS-1)*BL +: BL] = top[BL-1:0];
                    t_next[NUM_BLOCKS*BL +: BL] = t[(NUM_BLOCKS+1)*BL +: BL] + {{(BL-1){1'b0}}, top[BL]};
                    t_next[(NUM_BLOCKS+1)*BL +: BL] = '0;
                    carry_next = '0;
                end
            end
            default: ;
        endcase
    end

`ifdef MONTGOMERY_FINAL_SUB_EN
    logic [DATA_LENGTH-1:0] d, d_next;
    logic [BL:0]            diff;
    logic                   borrow, borrow_next, use_diff;

    // Limb-serial t - m with borrow chain; the difference is kept only if t >= m
    always_comb begin
        d_next      = d;
        borrow_next = borrow;
        diff        = '0;
        if (state == IDLE) begin
            borrow_next = 1'b0;
        end else if (state == SUB) begin
            diff = {1'b0, t[jb +: BL]} - {1'b0, m_r[jb +: BL]} - {{BL{1'b0}}, borrow};
            d_next[jb +: BL] = diff[BL-1:0];
            borrow_next = diff[BL];
        end
        use_diff = (t[NUM_BLOCKS*BL +: BL] != '0) || !borrow_next;
    end

    // Subtraction state registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            d      <= '0;
            borrow <= 1'b0;
        end else begin
            d      <= d_next;
            borrow <= borrow_next;
        end
    end
`endif

    // Next-state logic
    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = MUL;
            MUL:    if (j_last) state_next = QCALC;
            QCALC:  state_next = RED;
            RED:    if (j_last) state_next = i_last ? AFTER_RED : MUL;
            SUB:    if (j_last) state_next = FINISH;
            FINISH: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // State, counters, operand latches, accumulator and result registers
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state   <= IDLE;
            a_r     <= '0;
            b_r     <= '0;
            m_r     <= '0;
            mp_r    <= '0;
            q       <= '0;
            t       <= '0;
            carry   <= '0;
            i_cnt   <= '0;
            j_cnt   <= '0;
            result  <= '0;
            error_r <= 1'b0;
        end else begin
            state   <= state_next;
            t       <= t_next;
            carry   <= carry_next;
            error_r <= (state == IDLE) && start_i && !m_i[0];
            if (accept) begin
                a_r   <= a_i;
                b_r   <= b_i;
                m_r   <= m_i;
                mp_r  <= m_prime_i;
                i_cnt <= '0;
                j_cnt <= '0;
            end
            if (state == MUL || state == RED || state == SUB)
                j_cnt <= j_last ? '0 : j_cnt + CW'(1);
            if (state == RED && j_last)
                i_cnt <= i_last ? '0 : i_cnt + CW'(1);
            if (state == QCALC)
                q <= prod[BL-1:0];
`ifdef MONTGOMERY_FINAL_SUB_EN
            if (state == SUB && j_last)
                result <= use_diff ? d_next : t[DATA_LENGTH-1:0];
`else
            // t < 2m can still overflow DATA_LENGTH bits when m is close to 2^DATA_LENGTH;
            // in that case t > m, and dropping the top bit then adding 2^DL - m gives t - m.
            if (state == RED && j_last && i_last)
                result <= t_next[DATA_LENGTH] ? (t_next[DATA_LENGTH-1:0] - m_r)
                                              : t_next[DATA_LENGTH-1:0];
`endif
        end
    end
endmodule

// File: tb/tb_montgomery_cios_serial.sv
// Directed and random bench for montgomery_cios_serial (64-bit operands, 16-bit limbs).
module tb_montgomery_cios_serial;
    localparam logic [63:0] M = 64'hFFFF_FFFF_FFFF_FFC5;
`ifdef MONTGOMERY_FINAL_SUB_EN
    localparam int EXP_LAT = 41;
`else
    localparam int EXP_LAT = 37;
`endif

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic        start_i = 1'b0;
    logic [63:0] a_i = '0, b_i = '0, m_i = '0;
    logic [15:0] m_prime_i = '0;
    logic        busy_o, done_o, error_o;
    logic [63:0] result_o;
    logic [2:0]  dbg_state;

    logic [63:0] exp_q[$];
    logic [15:0] mprime;
    int n_cmp = 0, n_err = 0, done_cnt = 0, err_cnt = 0, n_done_exp = 0;

    typedef struct packed {
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] exp;
        logic        hold;
    } vec_t;
    vec_t vecs[4];

    montgomery_cios_serial #(.DATA_LENGTH(64), .BLOCK_LENGTH(16)) dut (
        .clk_i(clk), .reset_i(reset_i), .start_i(start_i),
        .a_i(a_i), .b_i(b_i), .m_i(m_i), .m_prime_i(m_prime_i),
        .busy_o(busy_o), .done_o(done_o), .error_o(error_o),
        .result_o(result_o), .dbg_state(dbg_state)
    );

    // Clock
    always #5 clk = ~clk;

    // Pulse counters
    always @(negedge clk) begin
        if (done_o) done_cnt <= done_cnt + 1;
        if (error_o) err_cnt <= err_cnt + 1;
    end

    function automatic logic [15:0] calc_mprime(input logic [63:0] m);
        logic [15:0] inv;
        inv = m[15:0];
        for (int k = 0; k < 5; k++) inv = inv * (16'd2 - m[15:0] * inv);
        return 16'd0 - inv;
    endfunction

    // Reference: reduce a*b mod m, then halve modulo m DATA_LENGTH times
    function automatic logic [63:0] mont_ref(input logic [63:0] a, input logic [63:0] b);
        logic [127:0] p;
        logic [64:0]  x;
        p = {64'h0, a} * {64'h0, b};
        p = p % {64'h0, M};
        x = {1'b0, p[63:0]};
        for (int k = 0; k < 64; k++) begin
            if (x[0]) x = x + {1'b0, M};
            x = x >> 1;
        end
        return x[63:0];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: actual %h required %h", name, act, exp);
        end
    endtask

    task automatic run_op(input logic [63:0] a, input logic [63:0] b, input logic [63:0] exp,
                          input logic hold, input string tag);
        int lat;
        logic got, stable;
        logic [63:0] prev, want;
        @(negedge clk);
        check($sformatf("idle_%s", tag), {62'd0, busy_o, done_o}, 64'd0);
        prev = result_o;
        exp_q.push_back(exp);
        a_i = a; b_i = b; m_i = M; m_prime_i = mprime; start_i = 1'b1;
        lat = 0; got = 1'b0; stable = 1'b1;
        while (!got && lat < 200) begin
            @(negedge clk);
            lat++;
            if (!hold) start_i = 1'b0;
            a_i = {$urandom, $urandom};
            b_i = {$urandom, $urandom};
            m_i = {$urandom, $urandom} | 64'h1;
            m_prime_i = 16'($urandom);
            if (done_o) got = 1'b1;
            else if (busy_o !== 1'b1 || result_o !== prev) stable = 1'b0;
        end
        start_i = 1'b0;
        want = exp_q.pop_front();
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL timeout_%s: no done_o after %0d cycles, required %0d", tag, lat, EXP_LAT);
        end else begin
            n_done_exp++;
            check($sformatf("latency_%s", tag), 64'(lat), 64'(EXP_LAT));
            check($sformatf("stable_%s", tag), {63'd0, stable}, 64'd1);
`ifdef MONTGOMERY_FINAL_SUB_EN
            check($sformatf("result_%s", tag), result_o, want);
`else
            check($sformatf("result_mod_%s", tag), result_o % M, want);
`endif
        end
    endtask

    task automatic abort_op(input int at_cycle, input string tag);
        @(negedge clk);
        a_i = 64'h1234_5678_9ABC_DEF0; b_i = 64'h0FED_CBA9_8765_4321;
        m_i = M; m_prime_i = mprime; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        repeat (at_cycle - 1) @(negedge clk);
        check($sformatf("busy_before_rst_%s", tag), {63'd0, busy_o}, 64'd1);
        reset_i = 1'b1;
        @(negedge clk);
        check($sformatf("rst_outputs_%s", tag), {61'd0, busy_o, done_o, error_o}, 64'd0);
        check($sformatf("rst_result_%s", tag), result_o, 64'd0);
        reset_i = 1'b0;
    endtask

    initial begin
        logic [63:0] prev, a, b;
        int dc, ec;
        mprime = calc_mprime(M);

        // Reset
        repeat (3) @(negedge clk);
        check("reset_flags", {61'd0, busy_o, done_o, error_o}, 64'd0);
        check("reset_result", result_o, 64'd0);
        check("reset_state", {61'd0, dbg_state}, 64'd0);
        reset_i = 1'b0;

        // Directed table, back-to-back, the last two with start_i held through busy
        vecs[0] = '{a: 64'h1,  b: 64'h3B,  exp: 64'h1,  hold: 1'b0};
        vecs[1] = '{a: 64'h3B, b: 64'h3B,  exp: 64'h3B, hold: 1'b0};
        vecs[2] = '{a: 64'h0,  b: M - 1,   exp: 64'h0,  hold: 1'b1};
        vecs[3] = '{a: M - 1,  b: M - 1,   exp: mont_ref(M - 1, M - 1), hold: 1'b1};
        for (int v = 0; v < 4; v++)
            run_op(vecs[v].a, vecs[v].b, vecs[v].exp, vecs[v].hold, $sformatf("vec%0d", v));
        repeat (60) @(negedge clk);
        check("done_count_table", 64'(done_cnt), 64'(n_done_exp));
        check("no_error_while_busy", 64'(err_cnt), 64'd0);
        check("idle_after_table", {63'd0, busy_o}, 64'd0);

        // Even modulus is rejected
        @(negedge clk);
        prev = result_o;
        ec = err_cnt;
        a_i = 64'h5; b_i = 64'h7; m_i = 64'hFFFF_FFFF_FFFF_FFC4; start_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0;
        check("reject_error", {63'd0, error_o}, 64'd1);
        check("reject_busy", {63'd0, busy_o}, 64'd0);
        check("reject_result", result_o, prev);
        @(negedge clk);
        check("reject_pulse_end", {62'd0, error_o, busy_o}, 64'd0);
        check("reject_result_hold", result_o, prev);
        check("reject_pulse_count", 64'(err_cnt), 64'(ec + 1));

        // Reset mid-operation, then idle to confirm the aborted op never completes
        abort_op(20, "a");
        dc = done_cnt;
        repeat (40) @(negedge clk);
        check("no_done_after_abort", 64'(done_cnt), 64'(dc));
        check("idle_after_abort", {63'd0, busy_o}, 64'd0);
        run_op(64'h3B, 64'h3B, 64'h3B, 1'b0, "after_abort");

        // Reset mid-operation, then start one cycle after release
        abort_op(20, "b");
        a = 64'hDEAD_BEEF_0123_4567;
        b = 64'h0BAD_F00D_89AB_CDEF;
        run_op(a, b, mont_ref(a, b), 1'b0, "restart");

        // Random operands below m
        for (int r = 0; r < 1000; r++) begin
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if (a >= M) a = a - M;
            if (b >= M) b = b - M;
            run_op(a, b, mont_ref(a, b), 1'($urandom_range(0, 1)), $sformatf("rnd%0d", r));
        end
        @(negedge clk);
        check("done_count_total", 64'(done_cnt), 64'(n_done_exp));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/montgomery_cios_serial.md
MONTGOMERY_CIOS_SERIAL -- requirements
Module: montgomery_cios_serial

Interface
REQ-001 SHALL have parameter DATA_LENGTH, default 64, meaning operand/modulus width in bits.
REQ-002 SHALL have parameter BLOCK_LENGTH, default 16, meaning limb width; derived NUM_BLOCKS = DATA_LENGTH/BLOCK_LENGTH; elaboration fails if not an exact divisor or NUM_BLOCKS < 2.
REQ-003 SHALL have port clk_i, input, 1, the single clock; all logic on rising edge.
REQ-004 SHALL have port reset_i, input, 1, reset, synchronous and active-high.
REQ-005 SHALL have port start_i, input, 1, request; sampled only in IDLE.
REQ-006 SHALL have ports a_i, b_i, m_i, each input, DATA_LENGTH, meaning multiplicand, multiplier and odd modulus.
REQ-007 SHALL have port m_prime_i, input, BLOCK_LENGTH, meaning -m^-1 mod 2^BLOCK_LENGTH.
REQ-008 SHALL have port busy_o, output, 1, high in every non-IDLE state.
REQ-009 SHALL have port done_o, output, 1, one-cycle completion pulse.
REQ-010 SHALL have port error_o, output, 1, one-cycle pulse on a rejected start.
REQ-011 SHALL have port result_o, output, DATA_LENGTH, a*b*2^(-DATA_LENGTH) mod m.

Function
REQ-012 SHALL latch a_i, b_i, m_i and m_prime_i on the edge where start_i=1 in IDLE; later input changes SHALL NOT affect the operation.
REQ-013 SHALL implement word-serial CIOS with exactly one BLOCK_LENGTH x BLOCK_LENGTH multiply per cycle, using states IDLE, MUL, QCALC, RED, SUB, FINISH.
REQ-014 SHALL, for each outer index i = 0..NUM_BLOCKS-1: spend NUM_BLOCKS cycles in MUL (t += a*b[i], limb j per cycle, carry into limb NUM_BLOCKS and NUM_BLOCKS+1); spend 1 cycle in QCALC (q = t[0]*m_prime mod 2^BLOCK_LENGTH); spend NUM_BLOCKS cycles in RED (t = (t + q*m) >> BLOCK_LENGTH, shift folded into the limb write).
REQ-015 SHALL size the accumulator t to DATA_LENGTH+2*BLOCK_LENGTH bits so that no carry is lost.
REQ-016 SHALL transition IDLE->MUL on accepted start, MUL->QCALC, QCALC->RED, RED->MUL while i<NUM_BLOCKS-1, RED->SUB (macro defined) or RED->FINISH (macro undefined) after the last i, SUB->FINISH after NUM_BLOCKS cycles, and FINISH->IDLE unconditionally.
REQ-017 SHALL assert done_o only during FINISH, with result_o valid in that same cycle.
REQ-018 SHALL hold result_o stable from FINISH until the next accepted start; result_o SHALL NOT change during computation.
REQ-019 SHALL give latency L = NUM_BLOCKS*(2*NUM_BLOCKS+1) + S + 1 cycles from the start-accept edge to done_o high, where S = NUM_BLOCKS with the macro and S = 0 without it (NUM_BLOCKS=4: 41 or 37 cycles).
REQ-020 SHALL ignore start_i while busy_o=1, with no error_o pulse.
REQ-021 SHALL reject a start with m_i[0]=0: error_o pulses the next cycle, state stays IDLE, and result_o is unchanged.
REQ-022 SHALL accept back-to-back operation: start_i high in the cycle after FINISH SHALL be accepted.
REQ-023 SHALL treat operands >= m as congruence-correct only; full reduction is guaranteed only when a, b < m.

Reset
REQ-024 SHALL, when reset_i=1 on a clock edge, go to IDLE, clear counters and accumulator, and set busy_o=0, done_o=0, error_o=0 and result_o=0.
REQ-025 SHALL let reset asserted mid-operation abort the computation with no done_o pulse; a start one cycle after reset release SHALL be accepted.

Configuration
REQ-026 SHALL, with macro MONTGOMERY_FINAL_SUB_EN defined, run SUB limb-serially (t - m with borrow, 1 limb/cycle) and output the difference if no borrow, else t, so that result_o < m.
REQ-027 SHALL, with MONTGOMERY_FINAL_SUB_EN undefined, omit SUB and output t[DATA_LENGTH-1:0] lazily reduced (result_o < 2m); the bench then checks result_o mod m.

Verification (DATA_LENGTH=64, BLOCK_LENGTH=16, m=0xFFFFFFFFFFFFFFC5, m_prime computed by the bench)
REQ-028 SHALL cover: a=1, b=0x3B -> done_o after 41 cycles (37 without the macro), result_o=0x1.
REQ-029 SHALL cover: a=0x3B, b=0x3B -> result_o=0x3B.
REQ-030 SHALL cover: a=0, b=m-1 -> result_o=0; then immediate restart with a=m-1, b=m-1 -> result_o = (m-1)^2*2^-64 mod m (bench model); start_i held high throughout busy -> exactly one done_o per operation.
REQ-031 SHALL cover: m_i=0xFFFFFFFFFFFFFFC4 with start_i -> error_o pulse, busy_o stays 0, result_o unchanged.
REQ-032 SHALL cover: reset_i pulsed at cycle 20 of an operation -> all outputs 0, no done_o; next start completes correctly.
REQ-033 SHALL cover: 1000 random a, b < m compared against a reference model; each result matches and done_o latency is constant.
